// File: rtl/fc_layer_sched_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_pkg;

  // Sequencer states: stream beats, wait for the neuron, store result, report.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH
  } fc_state_t;

  // Number of beats needed to cover one neuron's inputs.
  function automatic int beats(input int in_size, input int beat);
    return in_size / beat;
  endfunction

  // The input vector must split into a whole, nonzero number of beats.
  function automatic bit size_ok(input int in_size, input int beat);
    return (beat > 0) && (in_size >= beat) && ((in_size % beat) == 0);
  endfunction

endpackage

// File: rtl/fc_layer_sched.sv
// Sequencer for one fully-connected layer: streams input/weight beats from
// registered BRAMs into the neuron, waits for its result, stores the ReLU
// output per neuron and reports completion or a watchdog error.
module fc_layer_sched
  import fc_pkg::*;
#(
  parameter int IN_SIZE  = 64,
  parameter int OUT_SIZE = 10,
  parameter int BEAT     = 16,
  parameter int DWIDTH   = 16,
  parameter int AW       = 10,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [AW-1:0]     in_addr,
  output logic [AW-1:0]     w_addr,
  output logic [AW-1:0]     b_addr,
  output logic              pu_load_en,
  input  logic              pu_done,
  input  logic [DWIDTH-1:0] pu_result,
  output logic              res_we,
  output logic [AW-1:0]     res_addr,
  output logic [DWIDTH-1:0] res_data
);

  localparam int BEATS = beats(IN_SIZE, BEAT);
  localparam int WDW   = $clog2(TIMEOUT) + 1;

  localparam logic [AW-1:0]  LAST_BEAT   = AW'(BEATS - 1);
  localparam logic [AW-1:0]  LAST_NEURON = AW'(OUT_SIZE - 1);
  localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT - 1);

  // Reject an input size that does not split into whole beats.
  if (!size_ok(IN_SIZE, BEAT)) begin : g_bad_size
    $error("fc_layer_sched: IN_SIZE must be a nonzero multiple of BEAT");
  end

  fc_state_t         state, state_next;
  logic [AW-1:0]     beat, beat_next;
  logic [AW-1:0]     neuron, neuron_next;
  logic [WDW-1:0]    wd, wd_next;
  logic              err_next;
  logic [DWIDTH-1:0] res_data_next;

  // State, counters, sticky error and captured result.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      beat     <= '0;
      neuron   <= '0;
      wd       <= '0;
      err      <= 1'b0;
      res_data <= '0;
    end else begin
      state    <= state_next;
      beat     <= beat_next;
      neuron   <= neuron_next;
      wd       <= wd_next;
      err      <= err_next;
      res_data <= res_data_next;
    end
  end

  // Neuron load strobe trails the read strobe by the BRAM read latency.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pu_load_en <= 1'b0;
    end else begin
      pu_load_en <= mem_rd_en;
    end
  end

  // Next-state logic and per-state outputs; addresses are zero when unused.
  always_comb begin
    state_next    = state;
    beat_next     = beat;
    neuron_next   = neuron;
    wd_next       = wd;
    err_next      = err;
    res_data_next = res_data;
    busy          = (state != ST_IDLE);
    done          = 1'b0;
    mem_rd_en     = 1'b0;
    res_we        = 1'b0;
    in_addr       = '0;
    w_addr        = '0;
    b_addr        = '0;
    res_addr      = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          beat_next   = '0;
          neuron_next = '0;
          wd_next     = '0;
          err_next    = 1'b0;
          state_next  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_rd_en = 1'b1;
        in_addr   = beat;
        w_addr    = AW'(int'(neuron) * BEATS + int'(beat));
        b_addr    = neuron;
        if (beat == LAST_BEAT) begin
          beat_next  = '0;
          wd_next    = '0;
          state_next = ST_WAIT;
        end else begin
          beat_next = beat + 1'b1;
        end
      end

      ST_WAIT: begin
        wd_next = wd + 1'b1;
        // A result arriving on the expiry cycle still counts as success.
        if (pu_done) begin
          res_data_next = pu_result;
          state_next    = ST_WRITE;
        end else if (wd == WD_LAST) begin
          err_next   = 1'b1;
          state_next = ST_FINISH;
        end
      end

      ST_WRITE: begin
        res_we   = 1'b1;
        res_addr = neuron;
        if (neuron == LAST_NEURON) begin
          state_next = ST_FINISH;
        end else begin
          neuron_next = neuron + 1'b1;
          state_next  = ST_FETCH;
        end
      end

      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
